// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg -- shared definitions for the ALU slice.
//   * DATA_W_DEF     : default operand/result width
//   * OP_W           : opcode field width
//   * op_e           : opcode enumeration (ADD=00, SUB=01, AND=10, OR=11)
//   * *_LSB_DEF      : inst field bit positions at the default width
//   * opc_lsb/a_lsb/b_lsb : field positions for an arbitrary width
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int OP_W       = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_e;

    // inst layout: {opcode, A, B}, B in the least significant bits.
    function automatic int opc_lsb(input int w);
        return 2 * w;
    endfunction

    function automatic int a_lsb(input int w);
        return w;
    endfunction

    function automatic int b_lsb(input int w);
        return 0 * w;
    endfunction

    localparam int OPC_LSB_DEF = 2 * DATA_W_DEF;  // inst[9:8] at default width
    localparam int A_LSB_DEF   = DATA_W_DEF;      // inst[7:4]
    localparam int B_LSB_DEF   = 0;               // inst[3:0]

endpackage

// File: rtl/alu_if.sv
// -----------------------------------------------------------------------------
// alu_if -- instruction/result bus of the ALU.
//   in_valid  : instruction qualifier, sampled on the rising clock edge
//   inst      : {opcode, A, B}, width 2+2*DATA_W
//   ALU_Out   : registered result
//   out_valid : one-cycle pulse per accepted instruction
//   carry/zero/ovf : registered flags
// Handshake: valid-only. The ALU accepts every edge with in_valid=1 (there is
// no ready/backpressure); each accepted instruction yields exactly one
// out_valid pulse one cycle later.
// Modports: master = instruction source / result sink, slave = the ALU.
// -----------------------------------------------------------------------------
interface alu_if #(
    parameter int DATA_W = alu_pkg::DATA_W_DEF
);
    logic                  in_valid;
    logic [2*DATA_W+1:0]   inst;
    logic [DATA_W-1:0]     ALU_Out;
    logic                  out_valid;
    logic                  carry;
    logic                  zero;
    logic                  ovf;

    modport master (
        output in_valid, inst,
        input  ALU_Out, out_valid, carry, zero, ovf
    );

    modport slave (
        input  in_valid, inst,
        output ALU_Out, out_valid, carry, zero, ovf
    );
endinterface

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core -- purely combinational datapath.
//   op_i       : opcode (alu_pkg::op_e)
//   a_i, b_i   : operands, DATA_W bits
//   result_o   : result modulo 2^DATA_W
//   carry_o    : carry (ADD) / borrow (SUB), 0 for logic ops
//   zero_o     : result is all zeros
//   ovf_o      : signed overflow (ADD/SUB), 0 for logic ops
// -----------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  op_e               op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o,
    output logic              zero_o,
    output logic              ovf_o
);
    localparam int MSB = DATA_W - 1;

    // One extra bit: for ADD it is the carry out, for SUB it is set exactly
    // when the unsigned subtraction borrows (A < B).
    logic [DATA_W:0] sum_w;
    logic [DATA_W:0] diff_w;

    assign sum_w  = {1'b0, a_i} + {1'b0, b_i};
    assign diff_w = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        result_o = '0;
        carry_o  = 1'b0;
        ovf_o    = 1'b0;
        unique case (op_i)
            OP_ADD: begin
                result_o = sum_w[DATA_W-1:0];
                carry_o  = sum_w[DATA_W];
                ovf_o    = (a_i[MSB] == b_i[MSB]) && (sum_w[MSB] != a_i[MSB]);
            end
            OP_SUB: begin
                result_o = diff_w[DATA_W-1:0];
                carry_o  = diff_w[DATA_W];
                ovf_o    = (a_i[MSB] != b_i[MSB]) && (diff_w[MSB] != a_i[MSB]);
            end
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu -- one-cycle registered ALU.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : alu_if.slave (in_valid, inst in; ALU_Out, out_valid, flags out)
// Instruction accepted at edge N appears on ALU_Out/flags with out_valid=1
// after edge N. Idle edges hold ALU_Out and flags and drop out_valid.
// Build option: define ALU_FLAGS_EN to enable carry/zero/ovf; otherwise those
// outputs are tied to 0. All outputs come straight from registers.
// -----------------------------------------------------------------------------
module alu
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic  clk,
    input  logic  rst_n,
    alu_if.slave  bus
);
    localparam int OPC_LSB = opc_lsb(DATA_W);
    localparam int A_LSB   = a_lsb(DATA_W);
    localparam int B_LSB   = b_lsb(DATA_W);

    // Input decode
    op_e               op_w;
    logic [DATA_W-1:0] a_w;
    logic [DATA_W-1:0] b_w;

    assign op_w = op_e'(bus.inst[OPC_LSB +: OP_W]);
    assign a_w  = bus.inst[A_LSB +: DATA_W];
    assign b_w  = bus.inst[B_LSB +: DATA_W];

    logic [DATA_W-1:0] core_result;
    logic              core_carry;
    logic              core_zero;
    logic              core_ovf;

    alu_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .op_i     (op_w),
        .a_i      (a_w),
        .b_i      (b_w),
        .result_o (core_result),
        .carry_o  (core_carry),
        .zero_o   (core_zero),
        .ovf_o    (core_ovf)
    );

    // Result register and valid pipeline
    logic [DATA_W-1:0] alu_out_q, alu_out_d;
    logic              out_valid_q, out_valid_d;

    always_comb begin
        alu_out_d   = bus.in_valid ? core_result : alu_out_q;
        out_valid_d = bus.in_valid;
    end

    // Asynchronous reset also clears out_valid, so a result accepted just
    // before reset never produces a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            alu_out_q   <= alu_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.ALU_Out   = alu_out_q;
    assign bus.out_valid = out_valid_q;

`ifdef ALU_FLAGS_EN
    logic carry_q, carry_d;
    logic zero_q,  zero_d;
    logic ovf_q,   ovf_d;

    always_comb begin
        carry_d = bus.in_valid ? core_carry : carry_q;
        zero_d  = bus.in_valid ? core_zero  : zero_q;
        ovf_d   = bus.in_valid ? core_ovf   : ovf_q;
    end

    // zero resets to 1 to stay consistent with ALU_Out resetting to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            carry_q <= carry_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.carry = carry_q;
    assign bus.zero  = zero_q;
    assign bus.ovf   = ovf_q;
`else
    // Flags disabled: the core's raw flags are intentionally left unused.
    logic unused_flags;
    assign unused_flags = ^{core_carry, core_zero, core_ovf};

    assign bus.carry = 1'b0;
    assign bus.zero  = 1'b0;
    assign bus.ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu -- directed vectors with hand-computed results, scoreboard queue and
// a monitor that pops on every out_valid.
// Expected tuple packing: {ALU_Out[3:0], carry, zero, ovf}.
// -----------------------------------------------------------------------------
module tb_alu;
    localparam int DATA_W = 4;
    localparam int W      = DATA_W + 3;

`ifdef ALU_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    alu_if #(.DATA_W(DATA_W)) bus ();

    alu #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [W-1:0] mk_exp(input logic [DATA_W-1:0] o,
                                            input logic c, input logic z,
                                            input logic v);
        // Flags read as 0 when the feature is compiled out.
        return {o, c & FLAGS, z & FLAGS, v & FLAGS};
    endfunction

    function automatic logic [W-1:0] dut_tuple();
        return {bus.ALU_Out, bus.carry, bus.zero, bus.ovf};
    endfunction

    task automatic check(input string name, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got out=%b c=%b z=%b v=%b, expected out=%b c=%b z=%b v=%b",
                     name, got[W-1:3], got[2], got[1], got[0],
                     exp[W-1:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Monitor: every out_valid pulse must match the oldest expectation.
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out_valid: got out=%b with no pending instruction",
                             bus.ALU_Out);
                end else begin
                    e = exp_q.pop_front();
                    check("result", dut_tuple(), e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [9:0] inst, input logic [W-1:0] exp);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.inst     = inst;
        exp_q.push_back(exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.inst     = '0;
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct packed {
        logic [9:0]        inst;
        logic [DATA_W-1:0] o;
        logic              c;
        logic              z;
        logic              v;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{10'b00_1001_1000, 4'b0001, 1'b1, 1'b0, 1'b1}; // ADD wrap + ovf
        vecs[1] = '{10'b01_0011_0101, 4'b1110, 1'b1, 1'b0, 1'b0}; // SUB borrow
        vecs[2] = '{10'b01_0101_0101, 4'b0000, 1'b0, 1'b1, 1'b0}; // SUB to zero
        vecs[3] = '{10'b10_1100_1010, 4'b1000, 1'b0, 1'b0, 1'b0}; // AND
        vecs[4] = '{10'b11_1100_1010, 4'b1110, 1'b0, 1'b0, 1'b0}; // OR
        vecs[5] = '{10'b00_0111_0001, 4'b1000, 1'b0, 1'b0, 1'b1}; // ADD +ovf
        vecs[6] = '{10'b01_1000_0001, 4'b0111, 1'b0, 1'b0, 1'b1}; // SUB -ovf
        vecs[7] = '{10'b00_1111_0001, 4'b0000, 1'b1, 1'b1, 1'b0}; // ADD to zero
        vecs[8] = '{10'b10_0101_1010, 4'b0000, 1'b0, 1'b1, 1'b0}; // AND zero
        vecs[9] = '{10'b11_0000_0000, 4'b0000, 1'b0, 1'b1, 1'b0}; // OR zero
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] hold_exp;
        int budget;

        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        bus.inst     = '0;

        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        #1 check("reset_async", dut_tuple(), mk_exp(4'b0000, 1'b0, 1'b1, 1'b0));
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b, expected 0", bus.out_valid);
        end

        // Instructions presented during reset must be discarded.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.inst     = 10'b00_0001_0001;
        @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        idle(2);
        check("reset_discard", dut_tuple(), mk_exp(4'b0000, 1'b0, 1'b1, 1'b0));

        // Back-to-back directed vectors.
        for (int i = 0; i < 10; i++)
            send(vecs[i].inst, mk_exp(vecs[i].o, vecs[i].c, vecs[i].z, vecs[i].v));
        idle(2);

        // Hold: ADD 0011+0100 = 0111, then three idle cycles.
        hold_exp = mk_exp(4'b0111, 1'b0, 1'b0, 1'b0);
        send(10'b00_0011_0100, hold_exp);
        idle(1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_value", dut_tuple(), hold_exp);
            n_tests++;
            if (bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_out_valid: got %b, expected 0", bus.out_valid);
            end
        end

        // Mid-operation reset: accept an instruction, reset before next edge.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.inst     = 10'b00_0110_0011;
        @(posedge clk);
        #1;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.inst     = '0;
        @(negedge clk);
        check("midop_reset", dut_tuple(), mk_exp(4'b0000, 1'b0, 1'b1, 1'b0));
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_out_valid: got %b, expected 0", bus.out_valid);
        end
        rst_n = 1'b1;
        idle(1);

        // Recovery after reset.
        send(10'b00_0001_0001, mk_exp(4'b0010, 1'b0, 1'b0, 1'b0));
        idle(1);

        // Drain with a bounded wait.
        budget = 0;
        while (exp_q.size() != 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d results outstanding, expected 0",
                     exp_q.size());
        end

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter DATA_W, default 4, operand/result width; inst width is 2+2*DATA_W (10 at default).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  inst is sampled on a rising clk edge when high.
REQ-005 inst  input  2+2*DATA_W  instruction: [9:8] opcode, [7:4] operand A, [3:0] operand B (default width).
REQ-006 ALU_Out  output  DATA_W  registered result.
REQ-007 out_valid  output  1  high for exactly one cycle per accepted instruction.
REQ-008 carry  output  1  registered carry/borrow flag.
REQ-009 zero  output  1  registered zero flag.
REQ-010 ovf  output  1  registered signed-overflow flag.

Function
REQ-011 Opcode 00 ADD: ALU_Out = (A+B) mod 2^DATA_W; carry = bit DATA_W of the unsigned sum.
REQ-012 Opcode 01 SUB: ALU_Out = (A-B) mod 2^DATA_W; carry = 1 when A<B unsigned (borrow).
REQ-013 Opcode 10 AND: ALU_Out = A & B; carry = 0, ovf = 0.
REQ-014 Opcode 11 OR: ALU_Out = A | B; carry = 0, ovf = 0.
REQ-015 ovf for ADD: operands share a sign and the result sign differs; for SUB: operand signs differ and the result sign differs from A.
REQ-016 zero = 1 when ALU_Out is all zeros, for every opcode.
REQ-017 Latency is one cycle: inst accepted at edge N produces ALU_Out, flags and out_valid=1 after edge N.
REQ-018 in_valid low at an edge: ALU_Out and flags hold their previous values and out_valid = 0.
REQ-019 Back-to-back in_valid: one result per cycle, no stalls, no backpressure.
REQ-020 All arithmetic is unsigned at DATA_W+1 bits internally; results wrap modulo 2^DATA_W.
REQ-021 Outputs are driven only from registers; no combinational path from inst to any output.

Reset
REQ-022 rst_n low immediately forces ALU_Out=0, carry=0, ovf=0, out_valid=0, zero=1, regardless of clk.
REQ-023 An instruction presented during reset is discarded; the first result follows the first in_valid edge after rst_n rises.
REQ-024 Reset asserted mid-operation discards the pending result; no out_valid pulse is produced for it.

Configuration
REQ-025 Macro ALU_FLAGS_EN: when defined, carry, zero and ovf behave per REQ-011..REQ-016.
REQ-026 Without ALU_FLAGS_EN: carry, zero and ovf ports remain present and are tied to 0; ALU_Out and out_valid are unchanged.

Structure
REQ-027 A shared package holds the opcode enum (OP_ADD=00, OP_SUB=01, OP_AND=10, OP_OR=11), the DATA_W default and the inst field bit-position constants.
REQ-028 A single combinational sub-module alu_core computes result and raw flags from opcode, A and B; the alu top holds the input decode, output registers and the valid pipeline.

Verification
REQ-029 Reset: rst_n=0 with no clk edge -> ALU_Out=0000, zero=1, out_valid=0 immediately.
REQ-030 ADD wrap: inst=00_1001_1000, in_valid=1 -> next cycle ALU_Out=0001, carry=1, ovf=1, zero=0, out_valid=1.
REQ-031 SUB borrow: inst=01_0011_0101 -> ALU_Out=1110, carry=1, ovf=0; inst=01_0101_0101 -> ALU_Out=0000, zero=1, carry=0.
REQ-032 Logic: inst=10_1100_1010 -> ALU_Out=1000; inst=11_1100_1010 -> ALU_Out=1110; carry=0, ovf=0 for both.
REQ-033 Hold: valid ADD giving 0111 then in_valid=0 for 3 cycles -> ALU_Out stays 0111, out_valid=0 on those cycles.
REQ-034 Mid-operation reset: assert rst_n=0 between accept edge and the next edge -> outputs at reset values, no out_valid pulse; with ALU_FLAGS_EN undefined, flags stay 0 in all scenarios.
